// File: rtl/axi_lite_lsu_if.sv
// Core request/response channel plus AXI4-lite master channel of the LSU.
// master = the LSU side, slave = core + interconnect side.
interface axi_lite_lsu_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_W = DATA_WIDTH / 8;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic [1:0]            resp_err;

    logic                  axi_awvalid;
    logic                  axi_awready;
    logic [ADDR_WIDTH-1:0] axi_awaddr;
    logic [2:0]            axi_awprot;
    logic                  axi_wvalid;
    logic                  axi_wready;
    logic [DATA_WIDTH-1:0] axi_wdata;
    logic [STRB_W-1:0]     axi_wstrb;
    logic                  axi_bvalid;
    logic                  axi_bready;
    logic [1:0]            axi_bresp;
    logic                  axi_arvalid;
    logic                  axi_arready;
    logic [ADDR_WIDTH-1:0] axi_araddr;
    logic [2:0]            axi_arprot;
    logic                  axi_rvalid;
    logic                  axi_rready;
    logic [DATA_WIDTH-1:0] axi_rdata;
    logic [1:0]            axi_rresp;

    modport master (
        input  req_valid, req_we, req_size, req_signed,
        input  req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output axi_awvalid, axi_awaddr, axi_awprot,
        input  axi_awready,
        output axi_wvalid, axi_wdata, axi_wstrb,
        input  axi_wready,
        input  axi_bvalid, axi_bresp,
        output axi_bready,
        output axi_arvalid, axi_araddr, axi_arprot,
        input  axi_arready,
        input  axi_rvalid, axi_rdata, axi_rresp,
        output axi_rready
    );

    modport slave (
        output req_valid, req_we, req_size, req_signed,
        output req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  axi_awvalid, axi_awaddr, axi_awprot,
        output axi_awready,
        input  axi_wvalid, axi_wdata, axi_wstrb,
        output axi_wready,
        output axi_bvalid, axi_bresp,
        input  axi_bready,
        input  axi_arvalid, axi_araddr, axi_arprot,
        output axi_arready,
        output axi_rvalid, axi_rdata, axi_rresp,
        input  axi_rready
    );
endinterface

// File: rtl/axi_lite_lsu.sv
// Single-outstanding load/store unit: core requests to AXI4-lite master
// transactions with lane steering, extension and misalignment checking.
module axi_lite_lsu #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input logic            clk,
    input logic            rst,
    axi_lite_lsu_if.master bus
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LANE_W = $clog2(STRB_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WADDR,
        S_WRESP,
        S_RADDR,
        S_RDATA,
        S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            size_q, size_d;
    logic                  sext_q, sext_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  req_ready_q, req_ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            err_q, err_d;

    logic [LANE_W-1:0]     req_lane;
    logic [LANE_W-1:0]     lane_q;
    logic                  misaligned;
    logic [STRB_W-1:0]     req_strb;
    logic [DATA_WIDTH-1:0] rd_shift;
    logic [DATA_WIDTH-1:0] rd_mask;
    logic [DATA_WIDTH-1:0] rd_top;
    logic [DATA_WIDTH-1:0] rd_ext;
    logic                  rd_sign;
    logic                  aw_done;
    logic                  w_done;

    assign req_lane = bus.req_addr[LANE_W-1:0];
    assign lane_q   = addr_q[LANE_W-1:0];

    // Alignment and byte-enable pattern of the incoming request.
    always_comb begin
        misaligned = 1'b0;
        req_strb   = STRB_W'(4'h1);
        unique case (bus.req_size)
            2'd0: begin
                misaligned = 1'b0;
                req_strb   = STRB_W'(4'h1);
            end
            2'd1: begin
                misaligned = bus.req_addr[0];
                req_strb   = STRB_W'(4'h3);
            end
            2'd2: begin
                misaligned = |bus.req_addr[1:0];
                req_strb   = STRB_W'(4'hF);
            end
            2'd3: begin
                misaligned = (|bus.req_addr[2:0]) || (DATA_WIDTH == 32);
                req_strb   = STRB_W'(8'hFF);
            end
        endcase
    end

    // Right-align the read beat, keep the access width, then extend.
    always_comb begin
        rd_shift = bus.axi_rdata >> {lane_q, 3'b000};
        rd_mask  = '1;
        unique case (size_q)
            2'd0: rd_mask = DATA_WIDTH'(8'hFF);
            2'd1: rd_mask = DATA_WIDTH'(16'hFFFF);
            2'd2: rd_mask = DATA_WIDTH'(32'hFFFF_FFFF);
            2'd3: rd_mask = '1;
        endcase
        rd_top  = rd_mask ^ (rd_mask >> 1);
        rd_sign = sext_q & (|(rd_shift & rd_top));
        rd_ext  = (rd_shift & rd_mask) | (rd_sign ? ~rd_mask : '0);
    end

    assign aw_done = !awvalid_q || bus.axi_awready;
    assign w_done  = !wvalid_q || bus.axi_wready;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        sext_d       = sext_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = 1'b0;
        rdata_d      = rdata_q;
        err_d        = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    addr_d      = bus.req_addr;
                    size_d      = bus.req_size;
                    sext_d      = bus.req_signed;
                    wdata_d     = bus.req_wdata << {req_lane, 3'b000};
                    wstrb_d     = req_strb << req_lane;
                    req_ready_d = 1'b0;
                    if (misaligned) begin
                        state_d      = S_DONE;
                        resp_valid_d = 1'b1;
                        err_d        = 2'b01;
                        rdata_d      = '0;
                    end else if (bus.req_we) begin
                        state_d   = S_WADDR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = S_RADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            S_WADDR: begin
                if (awvalid_q && bus.axi_awready) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && bus.axi_wready) begin
                    wvalid_d = 1'b0;
                end
                if (aw_done && w_done) begin
                    state_d  = S_WRESP;
                    bready_d = 1'b1;
                end
            end
            S_WRESP: begin
                if (bus.axi_bvalid) begin
                    state_d      = S_DONE;
                    bready_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    rdata_d      = '0;
                    // EXOKAY is not meaningful for single beats: treat as OK.
                    err_d        = bus.axi_bresp[1] ? bus.axi_bresp : 2'b00;
                end
            end
            S_RADDR: begin
                if (bus.axi_arready) begin
                    state_d   = S_RDATA;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            S_RDATA: begin
                if (bus.axi_rvalid) begin
                    state_d      = S_DONE;
                    rready_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    err_d        = bus.axi_rresp[1] ? bus.axi_rresp : 2'b00;
                    rdata_d      = bus.axi_rresp[1] ? '0 : rd_ext;
                end
            end
            S_DONE: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
                rdata_d     = '0;
                err_d       = 2'b00;
            end
            default: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            size_q       <= 2'b00;
            sext_q       <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 2'b00;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            sext_q       <= sext_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_rdata  = rdata_q;
    assign bus.resp_err    = err_q;
    assign bus.axi_awvalid = awvalid_q;
    assign bus.axi_awaddr  = addr_q;
    assign bus.axi_awprot  = 3'b000;
    assign bus.axi_wvalid  = wvalid_q;
    assign bus.axi_wdata   = wdata_q;
    assign bus.axi_wstrb   = wstrb_q;
    assign bus.axi_bready  = bready_q;
    assign bus.axi_arvalid = arvalid_q;
    assign bus.axi_araddr  = addr_q;
    assign bus.axi_arprot  = 3'b000;
    assign bus.axi_rready  = rready_q;
endmodule

// File: tb/tb_axi_lite_lsu.sv
// Scoreboard bench for axi_lite_lsu: 32-bit and 64-bit instances.
module tb_axi_lite_lsu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_lite_lsu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b32 ();
    axi_lite_lsu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) b64 ();

    axi_lite_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) u32 (
        .clk(clk), .rst(rst), .bus(b32.master)
    );
    axi_lite_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) u64 (
        .clk(clk), .rst(rst), .bus(b64.master)
    );

    typedef struct {
        logic [63:0] rdata;
        logic [1:0]  err;
        int          lat;
        int          hs;
        string       name;
    } exp_t;

    exp_t        q32[$];
    exp_t        q64[$];
    logic [31:0] awq[$];
    logic [35:0] wq[$];
    logic [31:0] arq[$];

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    logic [1:0]  bresp_cfg = 2'b00;
    logic [1:0]  rresp_cfg = 2'b00;
    logic [31:0] rdata_cfg = '0;
    logic [63:0] rdata64_cfg = '0;
    logic aw_seen = 1'b0, w_seen = 1'b0;
    int ar_cycles = 0;
    int resp_cnt32 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string nm, input logic [63:0] got,
                                  input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endfunction

    // 32-bit slave model, beat scoreboard and handshake-order checks
    always @(negedge clk) begin
        if (rst) begin
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            aw_seen = 1'b0; w_seen = 1'b0;
            b32.axi_awready = 1'b0; b32.axi_wready = 1'b0;
            b32.axi_bvalid = 1'b0; b32.axi_bresp = 2'b00;
            b32.axi_arready = 1'b0; b32.axi_rvalid = 1'b0;
            b32.axi_rdata = '0; b32.axi_rresp = 2'b00;
        end else begin
            if (w_seen && b32.axi_awvalid)
                check("skew/wvalid_dropped", 64'(b32.axi_wvalid), 64'd0);
            if (aw_seen && b32.axi_wvalid)
                check("skew/awvalid_dropped", 64'(b32.axi_awvalid), 64'd0);
            if (b32.axi_bready)
                check("bready_after_aw_w", {62'd0, aw_seen, w_seen}, 64'd3);
            if (b32.axi_arvalid) ar_cycles++;
            aw_cnt = b32.axi_awvalid ? aw_cnt + 1 : 0;
            w_cnt  = b32.axi_wvalid ? w_cnt + 1 : 0;
            b_cnt  = b32.axi_bready ? b_cnt + 1 : 0;
            ar_cnt = b32.axi_arvalid ? ar_cnt + 1 : 0;
            r_cnt  = b32.axi_rready ? r_cnt + 1 : 0;
            b32.axi_awready = b32.axi_awvalid && (aw_cnt > aw_dly);
            b32.axi_wready  = b32.axi_wvalid && (w_cnt > w_dly);
            b32.axi_bvalid  = b32.axi_bready && (b_cnt > b_dly);
            b32.axi_bresp   = bresp_cfg;
            b32.axi_arready = b32.axi_arvalid && (ar_cnt > ar_dly);
            b32.axi_rvalid  = b32.axi_rready && (r_cnt > r_dly);
            b32.axi_rdata   = rdata_cfg;
            b32.axi_rresp   = rresp_cfg;
            if (b32.axi_awvalid && b32.axi_awready) begin
                aw_seen = 1'b1;
                if (awq.size() == 0) check("aw_unexpected", 64'd1, 64'd0);
                else check("awaddr", 64'(b32.axi_awaddr), 64'(awq.pop_front()));
            end
            if (b32.axi_wvalid && b32.axi_wready) begin
                w_seen = 1'b1;
                if (wq.size() == 0) check("w_unexpected", 64'd1, 64'd0);
                else check("wdata_wstrb", 64'({b32.axi_wdata, b32.axi_wstrb}),
                           64'(wq.pop_front()));
            end
            if (b32.axi_arvalid && b32.axi_arready) begin
                if (arq.size() == 0) check("ar_unexpected", 64'd1, 64'd0);
                else check("araddr", 64'(b32.axi_araddr), 64'(arq.pop_front()));
            end
            if (b32.resp_valid) begin
                aw_seen = 1'b0;
                w_seen  = 1'b0;
            end
        end
    end

    // 64-bit slave: always ready, fixed read data
    always @(negedge clk) begin
        b64.axi_awready = !rst && b64.axi_awvalid;
        b64.axi_wready  = !rst && b64.axi_wvalid;
        b64.axi_bvalid  = !rst && b64.axi_bready;
        b64.axi_bresp   = 2'b00;
        b64.axi_arready = !rst && b64.axi_arvalid;
        b64.axi_rvalid  = !rst && b64.axi_rready;
        b64.axi_rdata   = rdata64_cfg;
        b64.axi_rresp   = 2'b00;
    end

    exp_t m32, m64;

    always @(negedge clk) begin
        if (!rst && b32.resp_valid) begin
            resp_cnt32++;
            if (q32.size() == 0) begin
                check("resp32_unexpected", 64'd1, 64'd0);
            end else begin
                m32 = q32.pop_front();
                check({m32.name, "/rdata"}, 64'(b32.resp_rdata), m32.rdata);
                check({m32.name, "/err"}, 64'(b32.resp_err), 64'(m32.err));
                if (m32.lat >= 0)
                    check({m32.name, "/lat"}, 64'(cyc - m32.hs), 64'(m32.lat));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b64.resp_valid) begin
            if (q64.size() == 0) begin
                check("resp64_unexpected", 64'd1, 64'd0);
            end else begin
                m64 = q64.pop_front();
                check({m64.name, "/rdata"}, b64.resp_rdata, m64.rdata);
                check({m64.name, "/err"}, 64'(b64.resp_err), 64'(m64.err));
                check({m64.name, "/lat"}, 64'(cyc - m64.hs), 64'(m64.lat));
            end
        end
    end

    task automatic issue32(input string nm, input logic we, input logic [1:0] sz,
                           input logic sx, input logic [31:0] addr,
                           input logic [31:0] wd, input logic axi,
                           input logic [31:0] exp_wd, input logic [3:0] exp_strb,
                           input logic [31:0] exp_rd, input logic [1:0] exp_err,
                           input int lat);
        exp_t e;
        int n = 0;
        @(negedge clk);
        while (!b32.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!b32.req_ready) begin
            check({nm, "/req_ready_timeout"}, 64'd0, 64'd1);
            return;
        end
        if (axi && we) begin
            awq.push_back(addr);
            wq.push_back({exp_wd, exp_strb});
        end else if (axi) begin
            arq.push_back(addr);
        end
        e.rdata = 64'(exp_rd);
        e.err = exp_err;
        e.lat = lat;
        e.hs = cyc;
        e.name = nm;
        q32.push_back(e);
        b32.req_we = we;
        b32.req_size = sz;
        b32.req_signed = sx;
        b32.req_addr = addr;
        b32.req_wdata = wd;
        b32.req_valid = 1'b1;
        @(negedge clk);
        b32.req_valid = 1'b0;
    endtask

    task automatic drain32(input string nm);
        int n = 0;
        while (q32.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (q32.size() != 0) begin
            check({nm, "/resp_timeout"}, 64'(q32.size()), 64'd0);
            q32.delete();
        end
        @(negedge clk);
    endtask

    task automatic issue64(input string nm, input logic [1:0] sz, input logic sx,
                           input logic [31:0] addr, input logic [63:0] exp_rd);
        exp_t e;
        int n = 0;
        @(negedge clk);
        while (!b64.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        e.rdata = exp_rd;
        e.err = 2'b00;
        e.lat = 3;
        e.hs = cyc;
        e.name = nm;
        q64.push_back(e);
        b64.req_we = 1'b0;
        b64.req_size = sz;
        b64.req_signed = sx;
        b64.req_addr = addr;
        b64.req_valid = 1'b1;
        @(negedge clk);
        b64.req_valid = 1'b0;
        n = 0;
        while (q64.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (q64.size() != 0) begin
            check({nm, "/resp_timeout"}, 64'(q64.size()), 64'd0);
            q64.delete();
        end
    endtask

    initial begin
        int n;
        int snap;
        b32.req_valid = 1'b0; b32.req_we = 1'b0; b32.req_size = 2'd0;
        b32.req_signed = 1'b0; b32.req_addr = '0; b32.req_wdata = '0;
        b64.req_valid = 1'b0; b64.req_we = 1'b0; b64.req_size = 2'd0;
        b64.req_signed = 1'b0; b64.req_addr = '0; b64.req_wdata = '0;
        repeat (3) @(negedge clk);
        check("reset/req_ready32", 64'(b32.req_ready), 64'd1);
        check("reset/outs32", 64'({b32.axi_awvalid, b32.axi_wvalid,
              b32.axi_bready, b32.axi_arvalid, b32.axi_rready,
              b32.resp_valid, b32.resp_err, b32.resp_rdata}), 64'd0);
        check("reset/req_ready64", 64'(b64.req_ready), 64'd1);
        check("reset/outs64", 64'({b64.axi_awvalid, b64.axi_wvalid,
              b64.axi_bready, b64.axi_arvalid, b64.axi_rready,
              b64.resp_valid, b64.resp_err}), 64'd0);
        rst = 1'b0;

        issue32("st_byte", 1, 0, 0, 32'h1003, 32'hAB, 1, 32'hAB00_0000, 4'h8, 0, 2'b00, 3);
        drain32("st_byte");
        rdata_cfg = 32'h8001_1234;
        issue32("ld_half_s", 0, 1, 1, 32'h2002, 0, 1, 0, 0, 32'hFFFF_8001, 2'b00, 3);
        drain32("ld_half_s");
        issue32("ld_half_u", 0, 1, 0, 32'h2002, 0, 1, 0, 0, 32'h0000_8001, 2'b00, 3);
        drain32("ld_half_u");
        issue32("st_half", 1, 1, 0, 32'h1002, 32'h1234_BEEF, 1, 32'hBEEF_0000, 4'hC, 0, 2'b00, 3);
        drain32("st_half");
        issue32("st_word", 1, 2, 0, 32'h4000, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 4'hF, 0, 2'b00, 3);
        drain32("st_word");

        aw_dly = 4;
        snap = resp_cnt32;
        issue32("skew", 1, 2, 0, 32'h5004, 32'h1122_3344, 1, 32'h1122_3344, 4'hF, 0, 2'b00, 7);
        drain32("skew");
        check("skew/resp_count", 64'(resp_cnt32 - snap), 64'd1);
        aw_dly = 0;

        snap = ar_cycles;
        issue32("mis_word", 0, 2, 0, 32'h3001, 0, 0, 0, 0, 0, 2'b01, 1);
        drain32("mis_word");
        issue32("dword32", 0, 3, 0, 32'h0010, 0, 0, 0, 0, 0, 2'b01, 1);
        drain32("dword32");
        issue32("mis_half_st", 1, 1, 0, 32'h1001, 32'h55, 0, 0, 0, 0, 2'b01, 1);
        drain32("mis_half_st");
        check("misaligned/no_arvalid", 64'(ar_cycles - snap), 64'd0);

        bresp_cfg = 2'b11;
        issue32("bresp_dec", 1, 2, 0, 32'h6000, 32'h0, 1, 32'h0, 4'hF, 0, 2'b11, 3);
        drain32("bresp_dec");
        bresp_cfg = 2'b01;
        issue32("bresp_exok", 1, 0, 0, 32'h6001, 32'h7E, 1, 32'h0000_7E00, 4'h2, 0, 2'b00, 3);
        drain32("bresp_exok");
        bresp_cfg = 2'b00;
        rresp_cfg = 2'b10;
        rdata_cfg = 32'hCAFE_F00D;
        issue32("rresp_slv", 0, 2, 0, 32'h7000, 0, 1, 0, 0, 32'h0, 2'b10, 3);
        drain32("rresp_slv");
        rresp_cfg = 2'b00;

        rdata_cfg = 32'h1234_8056;
        issue32("ld_byte_s", 0, 0, 1, 32'h2001, 0, 1, 0, 0, 32'hFFFF_FF80, 2'b00, 3);
        drain32("ld_byte_s");
        issue32("ld_byte_u", 0, 0, 0, 32'h2000, 0, 1, 0, 0, 32'h0000_0056, 2'b00, 3);
        drain32("ld_byte_u");
        ar_dly = 2;
        r_dly = 1;
        rdata_cfg = 32'h0BAD_CAFE;
        issue32("ld_stall", 0, 2, 1, 32'h9000, 0, 1, 0, 0, 32'h0BAD_CAFE, 2'b00, 6);
        drain32("ld_stall");
        ar_dly = 0;

        r_dly = 1000;
        issue32("rst_abort", 0, 2, 0, 32'h7100, 0, 1, 0, 0, 0, 2'b00, -1);
        n = 0;
        while (!b32.axi_rready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_abort/in_rdata", 64'(b32.axi_rready), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_abort/outs", 64'({b32.axi_awvalid, b32.axi_wvalid,
              b32.axi_bready, b32.axi_arvalid, b32.axi_rready,
              b32.resp_valid}), 64'd0);
        check("rst_abort/req_ready", 64'(b32.req_ready), 64'd1);
        q32.delete();
        @(negedge clk);
        rst = 1'b0;
        r_dly = 0;

        rdata64_cfg = 64'hFEDC_BA98_7654_3210;
        issue64("ld_dword64", 3, 1, 32'h0008, 64'hFEDC_BA98_7654_3210);
        issue64("ld_byte64_s", 0, 1, 32'h000D, 64'hFFFF_FFFF_FFFF_FFBA);
        issue64("ld_word64_u", 2, 0, 32'h000C, 64'h0000_0000_FEDC_BA98);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
